// File: rtl/div_clk_period_monitor.sv
// Measures period and high time of a divided clock sampled on clk, tracks lock
// against an expected period, and raises sticky mismatch/timeout flags.
module div_clk_period_monitor #(
  parameter int EXP_PERIOD = 5,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_PERIOD = 255,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_in,
  input  logic          clr_err,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_cnt,
  output logic          meas_valid,
  output logic          locked,
  output logic          mismatch_err,
  output logic          timeout_err
);

  localparam int SW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] EXP_C  = CW'(EXP_PERIOD);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_PERIOD);
  localparam logic [SW-1:0] LOCK_C = SW'(LOCK_COUNT);

  typedef enum logic [0:0] {SEEK = 1'b0, MEAS = 1'b1} state_t;

  state_t        state_r;
  logic          d1_r;
  logic          d2_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] hi_r;
  logic [SW-1:0] streak_r;

  logic          rise_s;
  logic          match_s;
  logic          mm_set_s;
  logic          to_set_s;
  logic [SW-1:0] streak_inc_s;

  // Edge detect, period comparison and error set conditions.
  always_comb begin
    rise_s   = d1_r & ~d2_r;
    match_s  = (cnt_r == EXP_C);
    mm_set_s = (state_r == MEAS) & rise_s & ~match_s;
    to_set_s = (state_r == MEAS) & ~rise_s & (cnt_r == MAX_C);
    if (streak_r >= LOCK_C) begin
      streak_inc_s = LOCK_C;
    end else begin
      streak_inc_s = streak_r + SW'(1'b1);
    end
  end

  // Sampler, measurement FSM, lock tracking and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= SEEK;
      d1_r         <= 1'b0;
      d2_r         <= 1'b0;
      cnt_r        <= '0;
      hi_r         <= '0;
      streak_r     <= '0;
      period       <= '0;
      high_cnt     <= '0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
      mismatch_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      d1_r       <= div_in;
      d2_r       <= d1_r;
      meas_valid <= 1'b0;
      case (state_r)
        SEEK: begin
          if (rise_s) begin
            state_r <= MEAS;
            cnt_r   <= CW'(1'b1);
            hi_r    <= CW'(1'b1);
          end else begin
            state_r <= SEEK;
          end
        end
        MEAS: begin
          if (rise_s) begin
            period     <= cnt_r;
            high_cnt   <= hi_r;
            meas_valid <= 1'b1;
            cnt_r      <= CW'(1'b1);
            hi_r       <= CW'(1'b1);
            if (match_s) begin
              streak_r <= streak_inc_s;
              locked   <= (streak_inc_s == LOCK_C);
            end else begin
              streak_r <= '0;
              locked   <= 1'b0;
            end
          end else if (cnt_r == MAX_C) begin
            // Divider output dead: drop the partial period and re-acquire.
            state_r  <= SEEK;
            streak_r <= '0;
            locked   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
            hi_r  <= hi_r + {{(CW-1){1'b0}}, d1_r};
          end
        end
        default: begin
          state_r  <= SEEK;
          streak_r <= '0;
          locked   <= 1'b0;
        end
      endcase
      // A set in the same cycle as clr_err takes priority.
      mismatch_err <= mm_set_s | (mismatch_err & ~clr_err);
      timeout_err  <= to_set_s | (timeout_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_div_clk_period_monitor.sv
// Directed and randomized stimulus for div_clk_period_monitor, checked every
// cycle against a reference model built from rise times and sample history.
module tb_div_clk_period_monitor;

  localparam int EXP  = 5;
  localparam int LCK  = 4;
  localparam int MAXP = 255;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          div_in = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_cnt;
  logic          meas_valid;
  logic          locked;
  logic          mismatch_err;
  logic          timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: sample history indexed by clk cycle, plus rise bookkeeping.
  bit smp [0:8191];
  int t = 2;
  int m_period = 0;
  int m_high = 0;
  bit m_mv = 1'b0;
  bit m_locked = 1'b0;
  bit m_mm = 1'b0;
  bit m_to = 1'b0;
  int streak = 0;
  bit tracking = 1'b0;
  int ref_t = 0;

  div_clk_period_monitor #(
    .EXP_PERIOD(EXP), .LOCK_COUNT(LCK), .MAX_PERIOD(MAXP), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .clr_err(clr_err),
    .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid),
    .locked(locked), .mismatch_err(mismatch_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // Expected register values after the posedge at which (v, c, r) were sampled.
  task automatic model_step(input logic v, input logic c, input logic r);
    bit rise;
    bit set_mm;
    bit set_to;
    int per;
    int hs;
    set_mm = 1'b0;
    set_to = 1'b0;
    if (!r) begin
      smp[t] = 1'b0;
      m_period = 0; m_high = 0; m_mv = 1'b0; m_locked = 1'b0;
      m_mm = 1'b0; m_to = 1'b0; streak = 0; tracking = 1'b0;
    end else begin
      smp[t] = v;
      rise = smp[t-1] && !smp[t-2];
      m_mv = 1'b0;
      if (rise) begin
        if (tracking) begin
          per = (t - 1) - ref_t;
          hs = 0;
          for (int j = ref_t; j <= t - 2; j++) hs += int'(smp[j]);
          m_period = per;
          m_high = hs;
          m_mv = 1'b1;
          if (per == EXP) begin
            streak = (streak + 1 > LCK) ? LCK : streak + 1;
            m_locked = (streak == LCK);
          end else begin
            streak = 0;
            m_locked = 1'b0;
            set_mm = 1'b1;
          end
        end
        tracking = 1'b1;
        ref_t = t - 1;
      end else if (tracking && ((t - 1) - ref_t == MAXP)) begin
        tracking = 1'b0;
        streak = 0;
        m_locked = 1'b0;
        set_to = 1'b1;
      end
      m_mm = set_mm ? 1'b1 : (c ? 1'b0 : m_mm);
      m_to = set_to ? 1'b1 : (c ? 1'b0 : m_to);
    end
    t++;
  endtask

  task automatic tick(input logic v, input logic c, input logic r);
    div_in = v;
    clr_err = c;
    rst = r;
    @(posedge clk);
    model_step(v, c, r);
    #1;
    chk("period", 32'(period), 32'(m_period));
    chk("high_cnt", 32'(high_cnt), 32'(m_high));
    chk("meas_valid", 32'(meas_valid), 32'(m_mv));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("mismatch_err", 32'(mismatch_err), 32'(m_mm));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  task automatic run_period(input int hi, input int lo, input int clr_idx);
    for (int i = 0; i < hi + lo; i++) tick(i < hi, i == clr_idx, 1'b1);
  endtask

  initial begin
    int hi;
    int lo;
    int ci;
    // Reset with div_in toggling.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);

    // Nominal 3-high/2-low pattern until lock.
    for (int k = 0; k < 5; k++) run_period(3, 2, -1);
    chk("lock_after_4", 32'(locked), 32'd1);
    chk("nominal_high", 32'(high_cnt), 32'd3);

    // One long period drops lock; five nominal periods re-lock.
    run_period(4, 3, -1);
    run_period(3, 2, -1);
    chk("long_unlock", 32'(locked), 32'd0);
    chk("long_period", 32'(period), 32'd7);
    for (int k = 0; k < 4; k++) run_period(3, 2, -1);
    chk("relock", 32'(locked), 32'd1);

    // Dead divider output.
    for (int k = 0; k < 300; k++) tick(1'b0, 1'b0, 1'b1);
    chk("timeout_flag", 32'(timeout_err), 32'd1);
    chk("timeout_unlock", 32'(locked), 32'd0);
    run_period(3, 2, -1);
    run_period(3, 2, -1);

    // clr_err racing a mismatch, then clr_err alone.
    run_period(4, 3, -1);
    run_period(3, 2, 1);
    chk("clr_vs_set", 32'(mismatch_err), 32'd1);
    run_period(3, 2, 3);
    chk("clr_mm", 32'(mismatch_err), 32'd0);
    chk("clr_to", 32'(timeout_err), 32'd0);

    // Reset mid-period while locked, then re-acquire.
    for (int k = 0; k < 4; k++) run_period(3, 2, -1);
    chk("pre_reset_lock", 32'(locked), 32'd1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("midreset_locked", 32'(locked), 32'd0);
    for (int k = 0; k < 5; k++) run_period(3, 2, -1);
    chk("reset_relock", 32'(locked), 32'd1);

    // Randomized periods with occasional clr_err.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        hi = 3;
        lo = 2;
      end else begin
        hi = $urandom_range(1, 6);
        lo = $urandom_range(1, 6);
      end
      ci = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, hi + lo - 1)) : -1;
      run_period(hi, lo, ci);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
